// File: rtl/secuenciador_pkg.sv
// Shared types for the word-serial adder: FSM states and the result flag bundle.
package secuenciador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/sumador_rebanada.sv
// Combinational N-bit slice adder with carry in/out.
module sumador_rebanada #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // One ripple slice; the carry-out is the extra top bit of the widened sum.
    assign {co, s} = (N+1)'(a) + (N+1)'(b) + (N+1)'(ci);

endmodule

// File: rtl/secuenciador_suma.sv
// Word-serial adder: adds two N*WORDS-bit operands one N-bit slice per cycle,
// LSW first, reusing a single slice adder, and reports N/Z/C/V flags.
// Optional macro SECUENCIADOR_SUB_EN adds an 'op' input selecting subtraction.
module secuenciador_suma
    import secuenciador_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
`ifdef SECUENCIADOR_SUB_EN
    input  logic               op,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_v
);

    localparam int unsigned W  = N * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic          zacc_q, zacc_d;
    logic [W-1:0]  sum_q, sum_d;
    flags_t        flags_q, flags_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [31:0]   off_c;
    logic [N-1:0]  sl_a_c, sl_b_c, sl_s_c;
    logic          sl_co_c;

    // Bit offset of the slice currently being processed.
    assign off_c  = 32'(idx_q) * 32'(N);
    assign sl_a_c = a_q[off_c +: N];
    assign sl_b_c = b_q[off_c +: N];

    // The single slice adder, shared across all RUN cycles.
    sumador_rebanada #(.N(N)) u_rebanada (
        .a  (sl_a_c),
        .b  (sl_b_c),
        .ci (carry_q),
        .s  (sl_s_c),
        .co (sl_co_c)
    );

    // Next-state and datapath updates; b_q holds the effective (possibly inverted) operand.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        sum_d     = sum_q;
        flags_d   = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
`ifdef SECUENCIADOR_SUB_EN
                    if (op) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[off_c +: N] = sl_s_c;
                carry_d           = sl_co_c;
                zacc_d            = zacc_q & ~(|sl_s_c);
                if (idx_q == IW'(WORDS - 1)) begin
                    flags_d.n = sl_s_c[N-1];
                    flags_d.z = zacc_q & ~(|sl_s_c);
                    flags_d.c = sl_co_c;
                    flags_d.v = ~(a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ sl_s_c[N-1]);
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flag_n    = flags_q.n;
    assign flag_z    = flags_q.z;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;

endmodule

// File: doc/secuenciador_suma.md
SECUENCIADOR_SUMA -- requirements
Module: secuenciador_suma

Interface
REQ-001 SHALL have parameter N, default 4: word width of the internal adder slice, in bits.
REQ-002 SHALL have parameter WORDS, default 4: number of words per operand, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and cin are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-007 SHALL have port a, input, N*WORDS bits: operand A.
REQ-008 SHALL have port b, input, N*WORDS bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: initial carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sum, output, N*WORDS bits: result.
REQ-013 SHALL have ports flag_n, flag_z, flag_c and flag_v, outputs, 1 bit each: the negative, zero, carry and overflow flags.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE SHALL drive in_ready=1; in_valid=1 SHALL capture a, b and cin, clear the word index and go to RUN.
REQ-016 RUN SHALL add one N-bit slice per cycle, LSW first, chaining each slice's carry-out into the next slice's carry-in, and SHALL write the slice result into the sum register.
REQ-017 RUN SHALL go to DONE after the slice with index WORDS-1; the index SHALL never exceed WORDS-1.
REQ-018 out_valid SHALL rise exactly WORDS cycles after the accepting edge; WORDS=1 gives 1 cycle.
REQ-019 In DONE, out_valid=1, and sum and flags SHALL hold stable until the cycle where out_ready=1; the FSM then returns to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored there, and operand registers SHALL not change.
REQ-021 A new operation SHALL be accepted no earlier than the cycle after the DONE handshake; there is no overlap.
REQ-022 flag_n SHALL be sum[N*WORDS-1].
REQ-023 flag_z SHALL be 1 iff all N*WORDS sum bits are 0, accumulated across slices.
REQ-024 flag_c SHALL be the carry-out of the final slice.
REQ-025 flag_v SHALL equal ~(a_msb ^ b_eff_msb) & (a_msb ^ sum_msb), where b_eff is the operand actually added.
REQ-026 sum and flags SHALL retain their last values in IDLE.

Reset
REQ-027 rst=1 SHALL force IDLE at any time, including mid-RUN and mid-DONE, abandoning any operation in progress.
REQ-028 Under reset, SHALL drive sum=0, all flags=0, out_valid=0, in_ready=1, word index=0 and internal carry=0.

Configuration
REQ-029 With macro SECUENCIADOR_SUB_EN defined, SHALL add input port op (1 bit), captured at acceptance.
REQ-030 With SECUENCIADOR_SUB_EN, op=1 SHALL add ~b with the initial carry forced to 1, ignoring cin; flag_c=1 means no borrow.
REQ-031 Without SECUENCIADOR_SUB_EN, SHALL have no op port and perform addition only.

Structure
REQ-032 Package secuenciador_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and a flags struct {n, z, c, v}.
REQ-033 The N-bit slice adder SHALL be the sub-module sumador_rebanada, combinational: a, b, ci -> s, co.
REQ-034 The top level SHALL instantiate exactly one sumador_rebanada, reused every RUN cycle.

Verification (N=4, WORDS=4)
REQ-035 a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, n=0 z=0 c=0 v=0; out_valid exactly 4 cycles after acceptance.
REQ-036 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, z=1 c=1 n=0 v=0.
REQ-037 a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, n=1 v=1 c=0 z=0.
REQ-038 out_ready held 0 for 3 cycles in DONE, with in_valid=1 and new operands -> sum and flags stable, in_ready=0, no capture; IDLE in the cycle after out_ready=1.
REQ-039 rst pulsed at the 2nd RUN cycle -> out_valid=0, sum=0, flags=0, in_ready=1 immediately; the next operation completes correctly.
REQ-040 With SECUENCIADOR_SUB_EN, a=0x0005, b=0x0007, op=1 -> sum=0xFFFE, n=1 c=0 v=0 z=0.
